sb_cfg_ctrl: RTL and testbench
==============================

# sb_cfg_ctrl

Configuration sequencer for one switch-box tile. Accepts read and write requests from the global config bus through a valid/ready handshake and decodes the tile ID. It drives the switch box's `config_addr`/`config_data`/`config_en` port and captures `read_data`. While configuration is in progress it holds the switch-box datapath `clk_en` low, plus a settle window afterwards. Sits between the tile's config-bus slice and the `sb` instance.

## Interface
- `TILE_ID`, 16'h0000: tile this controller answers to; compared with `cfg_req_addr[31:16]`.
- `NUM_REGS`, 1: number of SB config registers; valid register index range is 0..NUM_REGS-1.
- `SETTLE_CYCLES`, 2: cycles `sb_clk_en` stays low after a response completes; 0..15.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_req_valid` in 1: request valid.
- `cfg_req_ready` out 1: request ready.
- `cfg_req_write` in 1: 1 = write, 0 = read.
- `cfg_req_addr` in 32: bits [31:16] tile ID, bits [7:0] register index; other bits ignored.
- `cfg_req_data` in 32: write data.
- `cfg_rsp_valid` out 1: response valid.
- `cfg_rsp_ready` in 1: response ready.
- `cfg_rsp_data` out 32: read data or write echo.
- `cfg_rsp_err` out 1: bad register index or verify mismatch.
- `stall_req` in 1: external stall; forces `sb_clk_en` low.
- `sb_config_addr` out 32: to `sb.config_addr`.
- `sb_config_data` out 32: to `sb.config_data`.
- `sb_config_en` out 1: to `sb.config_en`; single-cycle write strobe.
- `sb_read_data` in 32: from `sb.read_data`; combinational from the addressed register.
- `sb_clk_en` out 1: to `sb.clk_en`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, APPLY, READ, RESP, SETTLE.
- `cfg_req_ready` = 1 in IDLE and SETTLE, 0 in all other states.
- Request handshake (valid & ready) with a tile mismatch:
  - Request is consumed and dropped.
  - No response; state unchanged.
  - A SETTLE countdown continues.
- Handshake with a tile match:
  - Latch address and data; cancel any SETTLE countdown.
  - Register index ≥ NUM_REGS → RESP with err=1, data=0.
  - Valid-index write → APPLY.
  - Valid-index read → READ.
- APPLY:
  - `sb_config_en`=1 for exactly this cycle; `sb_config_addr`/`sb_config_data` hold the latched values.
  - Next state is RESP, or READ when verify is compiled in.
- READ:
  - `sb_config_en`=0, address held.
  - `sb_read_data` is captured at the end of the cycle → RESP.
- RESP:
  - `cfg_rsp_valid`=1; data and err are stable until `cfg_rsp_ready`.
  - On the handshake: go to SETTLE with the counter loaded to SETTLE_CYCLES, or straight to IDLE if SETTLE_CYCLES=0.
- SETTLE: counter decrements each cycle; exits to IDLE when it reaches 0.
- Write response: data = written data, err = 0 (see Configuration for the verify case).
- `sb_clk_en` is registered:
  - Next value = (next_state == IDLE) & ~stall_req.
  - `stall_req` therefore takes effect one cycle later.
- Output registers `sb_config_addr`/`sb_config_data` keep their last value in IDLE.

## Timing
- Reset values:
  - State IDLE, so `cfg_req_ready`=1; requests are not accepted while `reset_n`=0.
  - `cfg_rsp_valid`=0, `cfg_rsp_data`=0, `cfg_rsp_err`=0.
  - `sb_config_en`=0, `sb_config_addr`=0, `sb_config_data`=0.
  - `sb_clk_en`=0, `busy`=0.
- `sb_clk_en` first rises on the cycle after reset release, if `stall_req`=0.
- Write accepted in cycle N:
  - `sb_clk_en` falls at N+1.
  - `sb_config_en` is high in N+1.
  - `cfg_rsp_valid` in N+2, or N+3 with verify.
- Read accepted in cycle N: address driven in N+1; `cfg_rsp_valid` in N+2 with the captured data.
- Response handshake in cycle M: `sb_clk_en` rises at M+SETTLE_CYCLES+1 unless another matching request arrives first.
- Back-to-back matching requests during SETTLE keep `sb_clk_en` continuously low.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight request is lost; no response is produced.

## Configuration
- Macro: `SB_CFG_READBACK_VERIFY_EN`.
- Defined: every write goes APPLY → READ → RESP.
  - The readback value is returned in `cfg_rsp_data`.
  - `cfg_rsp_err`=1 if the readback differs from the written data.
- Undefined: writes go APPLY → RESP; response data echoes the write data with err=0.

## Structure
- Package `sb_cfg_pkg` holds:
  - The state enum.
  - Address field constants: TILE_LSB=16, TILE_W=16, REG_IDX_W=8.
  - A response struct {data, err}.
- One sub-module, `sb_cfg_settle_cnt`:
  - 4-bit load/decrement counter with a `done` output.
  - Instantiated once.

## Test plan
- Reset, then write addr 32'h0000_0000, data 32'hABCD:
  - One-cycle `sb_config_en` with data ABCD.
  - Response data ABCD, err 0.
  - `sb_clk_en` low from accept until 3 cycles after the response handshake.
- Read addr 0 with SB holding 32'hFFFF → response data FFFF, err 0, latency 2 cycles after accept.
- Write to addr 32'h0001_0000 (tile mismatch) → accepted; no `sb_config_en`, no response, `sb_clk_en` unchanged.
- Read addr 32'h0000_0005 with NUM_REGS=1 → err 1, data 0, no SB access.
- Hold `cfg_rsp_ready`=0 for 5 cycles → `cfg_rsp_valid`/data stable, `cfg_req_ready`=0, `sb_clk_en` low throughout.
- With `SB_CFG_READBACK_VERIFY_EN`, SB model forcing readback 32'h00DD after writing 32'hAAAA → response data 00DD, err 1.

Source files
------------

// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_pkg
// Description : Shared types and address-field constants for the switch-box
//               configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_READ   = 3'd2,
        ST_RESP   = 3'd3,
        ST_SETTLE = 3'd4
    } sb_cfg_state_t;

    // Config-bus address layout: [31:16] tile ID, [7:0] register index
    localparam int TILE_LSB  = 16;
    localparam int TILE_W    = 16;
    localparam int REG_IDX_W = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } sb_cfg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/sb_cfg_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_settle_cnt
// Description : 4-bit load/decrement counter timing the post-config settle
//               window of the switch-box clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_cfg_settle_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // High when the decrement taken this cycle brings the count to zero
    assign done = (r_count <= 4'd1);

endmodule
`default_nettype wire

// File: rtl/sb_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_ctrl
// Description : Config-bus to switch-box configuration sequencer with clock
//               gating of the SB datapath during and after configuration.
//               Optional write readback verify: SB_CFG_READBACK_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_cfg_ctrl
    import sb_cfg_pkg::*;
#(
    parameter logic [15:0] TILE_ID       = 16'h0000,
    parameter int          NUM_REGS      = 1,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_req_valid,
    output logic        cfg_req_ready,
    input  logic        cfg_req_write,
    input  logic [31:0] cfg_req_addr,
    input  logic [31:0] cfg_req_data,
    output logic        cfg_rsp_valid,
    input  logic        cfg_rsp_ready,
    output logic [31:0] cfg_rsp_data,
    output logic        cfg_rsp_err,
    input  logic        stall_req,
    output logic [31:0] sb_config_addr,
    output logic [31:0] sb_config_data,
    output logic        sb_config_en,
    input  logic [31:0] sb_read_data,
    output logic        sb_clk_en,
    output logic        busy
);

    localparam logic [REG_IDX_W:0] c_num_regs = NUM_REGS[REG_IDX_W:0];
    localparam logic [3:0]         c_settle   = SETTLE_CYCLES[3:0];

    sb_cfg_state_t r_state;
    sb_cfg_state_t w_next_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic          r_is_write;
    sb_cfg_rsp_t   r_rsp;
    logic          r_clk_en;

    logic w_req_fire;
    logic w_tile_hit;
    logic w_idx_ok;
    logic w_accept;
    logic w_rsp_fire;
    logic w_settle_done;

    assign w_req_fire = cfg_req_valid & cfg_req_ready;
    assign w_tile_hit = (cfg_req_addr[TILE_LSB +: TILE_W] == TILE_ID);
    assign w_idx_ok   = ({1'b0, cfg_req_addr[REG_IDX_W-1:0]} < c_num_regs);
    assign w_accept   = w_req_fire & w_tile_hit;
    assign w_rsp_fire = cfg_rsp_valid & cfg_rsp_ready;

    sb_cfg_settle_cnt u_settle_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_rsp_fire),
        .load_val (c_settle),
        .dec      (r_state == ST_SETTLE),
        .done     (w_settle_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_SETTLE: begin
                // A matching request pre-empts any settle countdown in progress
                if (w_accept) begin
                    if (!w_idx_ok) begin
                        w_next_state = ST_RESP;
                    end else if (cfg_req_write) begin
                        w_next_state = ST_APPLY;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end else if ((r_state == ST_SETTLE) && w_settle_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_APPLY: begin
`ifdef SB_CFG_READBACK_VERIFY_EN
                w_next_state = ST_READ;
`else
                w_next_state = ST_RESP;
`endif
            end
            ST_READ: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (cfg_rsp_ready) begin
                    w_next_state = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_req_ready = 1'b0;
        cfg_rsp_valid = 1'b0;
        sb_config_en  = 1'b0;
        busy          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cfg_req_ready = 1'b1;
                busy          = 1'b0;
            end
            ST_SETTLE: cfg_req_ready = 1'b1;
            ST_APPLY:  sb_config_en  = 1'b1;
            ST_RESP:   cfg_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_is_write <= 1'b0;
            r_rsp      <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= cfg_req_addr;
                r_data     <= cfg_req_data;
                r_is_write <= cfg_req_write;
                if (!w_idx_ok) begin
                    r_rsp.data <= 32'd0;
                    r_rsp.err  <= 1'b1;
                end
            end
`ifndef SB_CFG_READBACK_VERIFY_EN
            if (r_state == ST_APPLY) begin
                r_rsp.data <= r_data;
                r_rsp.err  <= 1'b0;
            end
`endif
            // Reads never flag an error; writes only reach here for verify
            if (r_state == ST_READ) begin
                r_rsp.data <= sb_read_data;
                r_rsp.err  <= r_is_write & (sb_read_data != r_data);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_en <= 1'b0;
        end else begin
            r_clk_en <= (w_next_state == ST_IDLE) & ~stall_req;
        end
    end

    assign cfg_rsp_data   = r_rsp.data;
    assign cfg_rsp_err    = r_rsp.err;
    assign sb_config_addr = r_addr;
    assign sb_config_data = r_data;
    assign sb_clk_en      = r_clk_en;

endmodule
`default_nettype wire

// File: tb/tb_sb_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_cfg_ctrl
// Description : Randomized self-checking bench for sb_cfg_ctrl with a simple
//               switch-box register model and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_cfg_ctrl;

    localparam logic [15:0] TILE   = 16'h0000;
    localparam int          NREGS  = 4;
    localparam int          SETTLE = 2;

    logic        clk;
    logic        reset_n;
    logic        cfg_req_valid;
    logic        cfg_req_ready;
    logic        cfg_req_write;
    logic [31:0] cfg_req_addr;
    logic [31:0] cfg_req_data;
    logic        cfg_rsp_valid;
    logic        cfg_rsp_ready;
    logic [31:0] cfg_rsp_data;
    logic        cfg_rsp_err;
    logic        stall_req;
    logic [31:0] sb_config_addr;
    logic [31:0] sb_config_data;
    logic        sb_config_en;
    logic [31:0] sb_read_data;
    logic        sb_clk_en;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    sb_cfg_ctrl #(
        .TILE_ID       (TILE),
        .NUM_REGS      (NREGS),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_req_valid  (cfg_req_valid),
        .cfg_req_ready  (cfg_req_ready),
        .cfg_req_write  (cfg_req_write),
        .cfg_req_addr   (cfg_req_addr),
        .cfg_req_data   (cfg_req_data),
        .cfg_rsp_valid  (cfg_rsp_valid),
        .cfg_rsp_ready  (cfg_rsp_ready),
        .cfg_rsp_data   (cfg_rsp_data),
        .cfg_rsp_err    (cfg_rsp_err),
        .stall_req      (stall_req),
        .sb_config_addr (sb_config_addr),
        .sb_config_data (sb_config_data),
        .sb_config_en   (sb_config_en),
        .sb_read_data   (sb_read_data),
        .sb_clk_en      (sb_clk_en),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch-box register file model; sb_corrupt forces a bad readback
    logic [31:0] sb_regs [NREGS];
    logic        sb_clr;
    logic        sb_corrupt;

    always @(posedge clk) begin
        if (sb_clr) begin
            for (int i = 0; i < NREGS; i++) sb_regs[i] <= 32'd0;
        end else if (sb_config_en && (sb_config_addr[7:0] < 8'(NREGS))) begin
            sb_regs[sb_config_addr[1:0]] <= sb_config_data;
        end
    end

    always_comb begin
        sb_read_data = 32'd0;
        if (sb_corrupt) sb_read_data = 32'h0000_00DD;
        else if (sb_config_addr[7:0] < 8'(NREGS)) sb_read_data = sb_regs[sb_config_addr[1:0]];
    end

    int          en_cnt = 0;
    logic [31:0] en_addr;
    logic [31:0] en_data;

    always @(negedge clk) begin
        if (sb_config_en) begin
            en_cnt  <= en_cnt + 1;
            en_addr <= sb_config_addr;
            en_data <= sb_config_data;
        end
    end

    logic [31:0] exp_regs [NREGS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from its accept through response and the following gap cycles
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input int gap, input logic corrupt);
        logic        hit;
        logic        ok;
        int          idx;
        int          en_before;
        int          lat;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        hit       = (addr[31:16] == TILE);
        ok        = (int'(addr[7:0]) < NREGS);
        idx       = int'(addr[7:0]);
        en_before = en_cnt;
        exp_data  = 32'd0;
        exp_err   = 1'b0;
        exp_lat   = 2;
        if (hit && !ok) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (hit && we) begin
            exp_regs[idx] = wdata;
`ifdef SB_CFG_READBACK_VERIFY_EN
            exp_data = corrupt ? 32'h0000_00DD : wdata;
            exp_err  = (exp_data != wdata);
            exp_lat  = 3;
`else
            exp_data = wdata;
`endif
        end else if (hit) begin
            exp_data = exp_regs[idx];
        end

        sb_corrupt = corrupt;
        chk("req_ready", 32'(cfg_req_ready), 32'd1);
        cfg_req_valid = 1'b1;
        cfg_req_write = we;
        cfg_req_addr  = addr;
        cfg_req_data  = wdata;
        step();
        cfg_req_valid = 1'b0;

        if (!hit) begin
            for (int c = 0; c < 4; c++) begin
                chk("drop_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
                chk("drop_busy", 32'(busy), 32'd0);
                chk("drop_clk_en", 32'(sb_clk_en), 32'd1);
                step();
            end
            chk("drop_cfg_en", 32'(en_cnt - en_before), 32'd0);
            sb_corrupt = 1'b0;
            return;
        end

        lat = 1;
        while (!cfg_rsp_valid && lat < 12) begin
            chk("cfg_clk_en", 32'(sb_clk_en), 32'd0);
            step();
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("cfg_en_count", 32'(en_cnt - en_before), (ok && we) ? 32'd1 : 32'd0);
        if (ok && we) begin
            chk("cfg_en_addr", en_addr, addr);
            chk("cfg_en_data", en_data, wdata);
        end

        for (int h = 0; h < hold; h++) begin
            chk("hold_rsp_valid", 32'(cfg_rsp_valid), 32'd1);
            chk("hold_rsp_data", cfg_rsp_data, exp_data);
            chk("hold_req_ready", 32'(cfg_req_ready), 32'd0);
            chk("hold_clk_en", 32'(sb_clk_en), 32'd0);
            step();
        end
        chk("rsp_valid", 32'(cfg_rsp_valid), 32'd1);
        chk("rsp_data", cfg_rsp_data, exp_data);
        chk("rsp_err", 32'(cfg_rsp_err), 32'(exp_err));
        cfg_rsp_ready = 1'b1;
        step();
        cfg_rsp_ready = 1'b0;
        sb_corrupt    = 1'b0;

        for (int c = 1; c <= gap; c++) begin
            chk("settle_clk_en", 32'(sb_clk_en), 32'(c > SETTLE));
            chk("settle_busy", 32'(busy), 32'(c <= SETTLE));
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          nkind;
        int          gap;
        logic [31:0] addr;
        logic        we;
        logic        corrupt;

        reset_n       = 1'b0;
        sb_clr        = 1'b1;
        sb_corrupt    = 1'b0;
        cfg_req_valid = 1'b0;
        cfg_req_write = 1'b0;
        cfg_req_addr  = 32'd0;
        cfg_req_data  = 32'd0;
        cfg_rsp_ready = 1'b0;
        stall_req     = 1'b0;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'd0;
        repeat (3) step();

        chk("rst_req_ready", 32'(cfg_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
        chk("rst_rsp_data", cfg_rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(cfg_rsp_err), 32'd0);
        chk("rst_cfg_en", 32'(sb_config_en), 32'd0);
        chk("rst_cfg_addr", sb_config_addr, 32'd0);
        chk("rst_cfg_data", sb_config_data, 32'd0);
        chk("rst_clk_en", 32'(sb_clk_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        sb_clr  = 1'b0;
        reset_n = 1'b1;
        chk("rel_clk_en_low", 32'(sb_clk_en), 32'd0);
        step();
        chk("rel_clk_en_high", 32'(sb_clk_en), 32'd1);

        do_txn(1'b1, 32'h0000_0000, 32'h0000_ABCD, 0, SETTLE + 1, 1'b0);
        do_txn(1'b1, 32'h0000_0000, 32'h0000_FFFF, 0, SETTLE + 1, 1'b0);
        do_txn(1'b0, 32'h0000_0000, 32'd0, 0, SETTLE + 1, 1'b0);
        do_txn(1'b1, 32'h0001_0000, 32'h0000_1234, 0, 0, 1'b0);
        do_txn(1'b0, 32'h0000_0005, 32'd0, 0, SETTLE + 1, 1'b0);
        do_txn(1'b0, 32'h0000_0000, 32'd0, 5, 0, 1'b0);
        do_txn(1'b1, 32'h0000_0003, 32'h1357_9BDF, 1, 1, 1'b0);
        do_txn(1'b0, 32'h0000_0003, 32'd0, 0, SETTLE + 1, 1'b0);
`ifdef SB_CFG_READBACK_VERIFY_EN
        do_txn(1'b1, 32'h0000_0000, 32'h0000_AAAA, 0, SETTLE + 1, 1'b1);
`endif

        stall_req = 1'b1;
        chk("stall_lag", 32'(sb_clk_en), 32'd1);
        step();
        stall_req = 1'b0;
        chk("stall_low", 32'(sb_clk_en), 32'd0);
        step();
        chk("stall_release", 32'(sb_clk_en), 32'd1);

        // Reset while a write is in its apply cycle: nothing must survive
        cfg_req_valid = 1'b1;
        cfg_req_write = 1'b1;
        cfg_req_addr  = 32'h0000_0002;
        cfg_req_data  = 32'hDEAD_BEEF;
        step();
        cfg_req_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        chk("mid_rst_cfg_en", 32'(sb_config_en), 32'd0);
        chk("mid_rst_cfg_addr", sb_config_addr, 32'd0);
        chk("mid_rst_cfg_data", sb_config_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_clk_en", 32'(sb_clk_en), 32'd0);
        chk("mid_rst_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
            chk("post_rst_clk_en", 32'(sb_clk_en), 32'd1);
            step();
        end
        do_txn(1'b0, 32'h0000_0002, 32'd0, 0, SETTLE + 1, 1'b0);

        nkind = $urandom_range(0, 9);
        for (int t = 0; t < 150; t++) begin
            kind  = nkind;
            nkind = $urandom_range(0, 9);
            gap   = (nkind == 0) ? SETTLE + 1 + int'($urandom_range(0, 1))
                                 : int'($urandom_range(0, SETTLE + 2));
            we      = 1'($urandom_range(0, 1));
            corrupt = 1'b0;
            if (kind == 0) begin
                addr = {TILE ^ 16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
            end else if (kind == 1) begin
                addr = {TILE, 8'($urandom), 8'($urandom_range(NREGS, 255))};
            end else begin
                addr = {TILE, 8'($urandom), 8'($urandom_range(0, NREGS - 1))};
`ifdef SB_CFG_READBACK_VERIFY_EN
                corrupt = we & 1'($urandom_range(0, 1));
`endif
            end
            do_txn(we, addr, $urandom, int'($urandom_range(0, 3)), gap, corrupt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
